// File: rtl/ahb_mux_pkg.sv
// Shared encodings for the AHB-Lite response multiplexer and its built-in default slave.
package ahb_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ERR1 = 2'b01,
    ERR2 = 2'b10
  } def_state_t;

  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle AHB ERROR sequencer, plus the optional wait-state
// watchdog enabled by AHB_MUX_TIMEOUT_EN.
module ahb_default_slave
  import ahb_mux_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       capture_def,
  input  logic       slv_stall,
  output logic       def_hreadyout,
  output logic [1:0] def_hresp,
  output logic       htimeout,
  output def_state_t state
);

  def_state_t state_nxt;
  logic       to_fire;

`ifdef AHB_MUX_TIMEOUT_EN
  logic [9:0] to_cnt;
  logic       to_err;

  // Only a stall seen from IDLE counts; an ERROR sequence in flight restarts the count.
  assign to_fire = slv_stall && (state == IDLE) && (to_cnt == 10'(TIMEOUT_CYC - 1));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (slv_stall && (state == IDLE)) to_cnt <= to_cnt + 10'd1;
      else                              to_cnt <= '0;
      to_err <= to_fire && !capture_def;
    end
  end

  assign htimeout = (state == ERR1) && to_err;
`else
  logic unused_stall;
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign unused_stall = slv_stall;
  assign to_fire      = 1'b0;
  assign htimeout     = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    def_hreadyout = 1'b1;
    def_hresp     = HRESP_OKAY;
    case (state)
      IDLE: begin
        if (capture_def || to_fire) state_nxt = ERR1;
      end
      ERR1: begin
        def_hreadyout = 1'b0;
        def_hresp     = HRESP_ERROR;
        state_nxt     = ERR2;
      end
      ERR2: begin
        def_hresp = HRESP_ERROR;
        state_nxt = capture_def ? ERR1 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux_n.sv
// AHB-Lite slave-to-master response mux for NSLV slaves with a built-in default slave.
// Optional wait-state watchdog: define AHB_MUX_TIMEOUT_EN.
module ahb_resp_mux_n
  import ahb_mux_pkg::*;
#(
  parameter int NSLV        = 3,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic [NSLV-1:0]      hsel_vec,
  input  logic [1:0]           htrans,
  input  logic                 hready,
  input  logic [NSLV*DW-1:0]   hrdata_s,
  input  logic [NSLV-1:0]      hreadyout_s,
  input  logic [2*NSLV-1:0]    hresp_s,
  output logic [DW-1:0]        hrdata,
  output logic                 hreadyout,
  output logic [1:0]           hresp,
  output logic                 htimeout
);

  // Data-phase select: one-hot dsel_vec = SLV(i); dsel_def = DEF; neither = NONE.
  logic [NSLV-1:0] dsel_vec;
  logic            dsel_def;
  logic            addr_active;
  logic            addr_onehot;
  logic            capture_def;

  logic [DW-1:0]   mux_rdata;
  logic            mux_ready;
  logic [1:0]      mux_resp;
  logic            slv_stall;

  logic            def_hreadyout;
  logic [1:0]      def_hresp;
  def_state_t      def_state;
  logic            def_active;

  assign addr_active = is_active_trans(htrans);
  assign addr_onehot = $onehot(hsel_vec);
  assign capture_def = hready && addr_active && !addr_onehot;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dsel_vec <= '0;
      dsel_def <= 1'b0;
    end else if (hready) begin
      dsel_vec <= (addr_active && addr_onehot) ? hsel_vec : '0;
      dsel_def <= addr_active && !addr_onehot;
    end
  end

  always_comb begin
    mux_rdata = '0;
    mux_ready = 1'b0;
    mux_resp  = HRESP_OKAY;
    for (int i = 0; i < NSLV; i++) begin
      mux_rdata = mux_rdata | ({DW{dsel_vec[i]}} & hrdata_s[i*DW +: DW]);
      mux_ready = mux_ready | (dsel_vec[i] & hreadyout_s[i]);
      mux_resp  = mux_resp  | ({2{dsel_vec[i]}} & hresp_s[2*i +: 2]);
    end
  end

  assign slv_stall = (|dsel_vec) && !mux_ready;

  ahb_default_slave #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_default_slave (
    .hclk          (hclk),
    .hresetn       (hresetn),
    .capture_def   (capture_def),
    .slv_stall     (slv_stall),
    .def_hreadyout (def_hreadyout),
    .def_hresp     (def_hresp),
    .htimeout      (htimeout),
    .state         (def_state)
  );

  // A running ERROR sequence also covers a timed-out slave, whose outputs are then ignored.
  assign def_active = (def_state != IDLE);

  always_comb begin
    hrdata    = '0;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    if (def_active || dsel_def) begin
      hreadyout = def_hreadyout;
      hresp     = def_hresp;
    end else if (|dsel_vec) begin
      hrdata    = mux_rdata;
      hreadyout = mux_ready;
      hresp     = mux_resp;
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// Directed bench for ahb_resp_mux_n (NSLV=3, DW=32); covers the watchdog when AHB_MUX_TIMEOUT_EN is defined.
module tb_ahb_resp_mux_n;

  localparam int NSLV = 3;
  localparam int DW   = 32;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b01;

  logic                hclk;
  logic                hresetn;
  logic [NSLV-1:0]     hsel_vec;
  logic [1:0]          htrans;
  logic                hready;
  logic [NSLV*DW-1:0]  hrdata_s;
  logic [NSLV-1:0]     hreadyout_s;
  logic [2*NSLV-1:0]   hresp_s;
  logic [DW-1:0]       hrdata;
  logic                hreadyout;
  logic [1:0]          hresp;
  logic                htimeout;

  int vectors;
  int miscompares;

  ahb_resp_mux_n #(
    .NSLV        (NSLV),
    .DW          (DW),
    .TIMEOUT_CYC (16)
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hsel_vec    (hsel_vec),
    .htrans      (htrans),
    .hready      (hready),
    .hrdata_s    (hrdata_s),
    .hreadyout_s (hreadyout_s),
    .hresp_s     (hresp_s),
    .hrdata      (hrdata),
    .hreadyout   (hreadyout),
    .hresp       (hresp),
    .htimeout    (htimeout)
  );

  // Interconnect feeds the mux's own hreadyout back as the bus hready.
  assign hready = hreadyout;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr(input logic [1:0] t, input logic [NSLV-1:0] sel);
    htrans   = t;
    hsel_vec = sel;
  endtask

  task automatic set_slv(input int i, input logic [DW-1:0] d, input logic rdy, input logic [1:0] r);
    hrdata_s[i*DW +: DW] = d;
    hreadyout_s[i]       = rdy;
    hresp_s[2*i +: 2]    = r;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] e_rdata, input logic e_ready,
                     input logic [1:0] e_resp, input logic e_to);
    vectors++;
    assert (hrdata === e_rdata) else begin
      miscompares++;
      $error("FAIL %s hrdata got %h want %h", tag, hrdata, e_rdata);
    end
    assert (hreadyout === e_ready) else begin
      miscompares++;
      $error("FAIL %s hreadyout got %b want %b", tag, hreadyout, e_ready);
    end
    assert (hresp === e_resp) else begin
      miscompares++;
      $error("FAIL %s hresp got %b want %b", tag, hresp, e_resp);
    end
    assert (htimeout === e_to) else begin
      miscompares++;
      $error("FAIL %s htimeout got %b want %b", tag, htimeout, e_to);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    hresetn     = 1'b0;
    addr(2'b00, 3'b000);
    set_slv(0, 32'hAAAA_0000, 1'b1, OK);
    set_slv(1, 32'hCAFE_0001, 1'b1, OK);
    set_slv(2, 32'hBEEF_0002, 1'b1, OK);
    #3;
    chk("reset", 32'h0, 1'b1, OK, 1'b0);
    cyc();
    cyc();
    hresetn = 1'b1;
    cyc();
    chk("idle_after_reset", 32'h0, 1'b1, OK, 1'b0);

    // Single read from slave 1, then IDLE returns zero-wait OKAY with hrdata=0.
    addr(2'b10, 3'b010);
    cyc();
    addr(2'b00, 3'b000);
    chk("slv1_read", 32'hCAFE_0001, 1'b1, OK, 1'b0);
    cyc();
    chk("slv1_then_idle", 32'h0, 1'b1, OK, 1'b0);

    // SEQ to slave 2 passes its data; BUSY maps to NONE.
    addr(2'b11, 3'b100);
    cyc();
    addr(2'b01, 3'b100);
    chk("slv2_seq", 32'hBEEF_0002, 1'b1, OK, 1'b0);
    cyc();
    addr(2'b00, 3'b000);
    chk("busy_none", 32'h0, 1'b1, OK, 1'b0);

    // Unmapped select: two-cycle ERROR.
    addr(2'b10, 3'b000);
    cyc();
    addr(2'b00, 3'b000);
    chk("unmapped_err1", 32'h0, 1'b0, ERR, 1'b0);
    cyc();
    chk("unmapped_err2", 32'h0, 1'b1, ERR, 1'b0);
    cyc();
    chk("unmapped_done", 32'h0, 1'b1, OK, 1'b0);

    // Multi-hot select: same ERROR, data forced to zero.
    addr(2'b10, 3'b011);
    cyc();
    addr(2'b00, 3'b000);
    chk("multihot_err1", 32'h0, 1'b0, ERR, 1'b0);
    cyc();
    chk("multihot_err2", 32'h0, 1'b1, ERR, 1'b0);
    cyc();
    chk("multihot_done", 32'h0, 1'b1, OK, 1'b0);

    // Back-to-back: DEF captured in ERR2 re-enters ERR1; then slave 0 follows with no bubble.
    addr(2'b10, 3'b000);
    cyc();
    chk("b2b_err1_a", 32'h0, 1'b0, ERR, 1'b0);
    cyc();
    chk("b2b_err2_a", 32'h0, 1'b1, ERR, 1'b0);
    cyc();
    addr(2'b10, 3'b001);
    chk("b2b_err1_b", 32'h0, 1'b0, ERR, 1'b0);
    cyc();
    chk("b2b_err2_b", 32'h0, 1'b1, ERR, 1'b0);
    cyc();
    addr(2'b00, 3'b000);
    chk("b2b_slv0", 32'hAAAA_0000, 1'b1, OK, 1'b0);
    cyc();
    chk("b2b_idle", 32'h0, 1'b1, OK, 1'b0);

    // Slave 2 stalls 3 cycles while slave 0's address phase waits.
    set_slv(2, 32'hBEEF_0002, 1'b0, OK);
    addr(2'b10, 3'b100);
    cyc();
    addr(2'b10, 3'b001);
    chk("stall2_c1", 32'hBEEF_0002, 1'b0, OK, 1'b0);
    cyc();
    chk("stall2_c2", 32'hBEEF_0002, 1'b0, OK, 1'b0);
    cyc();
    chk("stall2_c3", 32'hBEEF_0002, 1'b0, OK, 1'b0);
    hreadyout_s[2] = 1'b1;
    #1;
    chk("stall2_release", 32'hBEEF_0002, 1'b1, OK, 1'b0);
    set_slv(0, 32'h1234_5678, 1'b1, OK);
    cyc();
    addr(2'b00, 3'b000);
    chk("after_stall_slv0", 32'h1234_5678, 1'b1, OK, 1'b0);

    // Slave ERROR response is passed through unchanged.
    set_slv(1, 32'hCAFE_0001, 1'b0, ERR);
    addr(2'b10, 3'b010);
    cyc();
    addr(2'b00, 3'b000);
    chk("slv1_err_first", 32'hCAFE_0001, 1'b0, ERR, 1'b0);
    set_slv(1, 32'hCAFE_0001, 1'b1, ERR);
    #1;
    chk("slv1_err_second", 32'hCAFE_0001, 1'b1, ERR, 1'b0);
    set_slv(1, 32'hCAFE_0001, 1'b1, OK);
    cyc();
    chk("slv1_err_done", 32'h0, 1'b1, OK, 1'b0);

    // Asynchronous reset in the middle of ERR1.
    addr(2'b10, 3'b000);
    cyc();
    addr(2'b00, 3'b000);
    chk("pre_reset_err1", 32'h0, 1'b0, ERR, 1'b0);
    #2;
    hresetn = 1'b0;
    #1;
    chk("reset_mid_err1", 32'h0, 1'b1, OK, 1'b0);
    cyc();
    hresetn = 1'b1;
    cyc();
    chk("after_reset", 32'h0, 1'b1, OK, 1'b0);

`ifdef AHB_MUX_TIMEOUT_EN
    // Slave 0 stalls: ERR1 with htimeout on stall cycle 16, ERR2 on 17, slave ignored after.
    set_slv(0, 32'h5555_0000, 1'b0, OK);
    addr(2'b10, 3'b001);
    cyc();
    addr(2'b00, 3'b000);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("to_stall%0d", k), 32'h5555_0000, 1'b0, OK, 1'b0);
      cyc();
    end
    set_slv(0, 32'h6666_0000, 1'b1, ERR);
    chk("to_err1", 32'h0, 1'b0, ERR, 1'b1);
    cyc();
    chk("to_err2", 32'h0, 1'b1, ERR, 1'b0);
    set_slv(0, 32'h7777_0000, 1'b0, OK);
    cyc();
    chk("to_done", 32'h0, 1'b1, OK, 1'b0);
    set_slv(0, 32'hAAAA_0000, 1'b1, OK);
`else
    // Without the watchdog a slave may stall indefinitely.
    set_slv(0, 32'h5555_0000, 1'b0, OK);
    addr(2'b10, 3'b001);
    cyc();
    addr(2'b00, 3'b000);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("long_stall%0d", k), 32'h5555_0000, 1'b0, OK, 1'b0);
      cyc();
    end
    hreadyout_s[0] = 1'b1;
    #1;
    chk("long_stall_release", 32'h5555_0000, 1'b1, OK, 1'b0);
    cyc();
    chk("long_stall_done", 32'h0, 1'b1, OK, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
